// File: rtl/bcd_seven_seg_driver.sv
// bcd_seven_seg_driver: converts a 10-bit unsigned value to four active-low
// 7-segment digits with a serial shift-and-add-3 (double-dabble) engine.
// A new conversion starts whenever VALUE differs from the value last shown.
// Latency: 12 rising edges from the capture edge, inclusive (capture, 10
// conversion steps, then the HEX load). HEX outputs hold their old value until
// the load edge. VALUE is sampled only in IDLE.
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   VALUE[9:0]          unsigned value to display (0..1023)
//   HEX0..HEX3[7:0]     ones..thousands digit, active-low {DP,g,f,e,d,c,b,a}
//   BUSY                high while a conversion is in flight (CONVERT/LOAD)
module bcd_seven_seg_driver #(
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [9:0] VALUE,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2,
  output logic [7:0] HEX3,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_LOAD    = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  state_t      state, state_n;
  logic [9:0]  shift_reg, shift_reg_n;
  logic [15:0] bcd, bcd_n;
  logic [3:0]  cnt, cnt_n;
  logic [9:0]  last, last_n;
  logic [9:0]  captured, captured_n;
  logic        shown_valid, shown_valid_n;
  logic [7:0]  hex0_q, hex1_q, hex2_q, hex3_q;
  logic [7:0]  hex0_n, hex1_n, hex2_n, hex3_n;

  // Active-low segment code for one BCD nibble; codes 10..15 cannot occur
  // after a full conversion and are shown as blank.
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Pre-shift correction: any nibble >= 5 gets +3 so the following doubling
  // carries correctly into the next decimal digit.
  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    end
    return r;
  endfunction

  // Leading-zero detection on the finished BCD result.
  logic blank3, blank2, blank1;
  assign blank3 = BLANK_LEADING && (bcd[15:12] == 4'd0);
  assign blank2 = blank3 && (bcd[11:8] == 4'd0);
  assign blank1 = blank2 && (bcd[7:4] == 4'd0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      shift_reg   <= '0;
      bcd         <= '0;
      cnt         <= '0;
      last        <= '0;
      captured    <= '0;
      shown_valid <= 1'b0;
      hex0_q      <= SEG_BLANK;
      hex1_q      <= SEG_BLANK;
      hex2_q      <= SEG_BLANK;
      hex3_q      <= SEG_BLANK;
    end else begin
      state       <= state_n;
      shift_reg   <= shift_reg_n;
      bcd         <= bcd_n;
      cnt         <= cnt_n;
      last        <= last_n;
      captured    <= captured_n;
      shown_valid <= shown_valid_n;
      hex0_q      <= hex0_n;
      hex1_q      <= hex1_n;
      hex2_q      <= hex2_n;
      hex3_q      <= hex3_n;
    end
  end

  always_comb begin
    state_n       = state;
    shift_reg_n   = shift_reg;
    bcd_n         = bcd;
    cnt_n         = cnt;
    last_n        = last;
    captured_n    = captured;
    shown_valid_n = shown_valid;
    hex0_n        = hex0_q;
    hex1_n        = hex1_q;
    hex2_n        = hex2_q;
    hex3_n        = hex3_q;

    case (state)
      S_IDLE: begin
        if ((VALUE != last) || !shown_valid) begin
          shift_reg_n = VALUE;
          captured_n  = VALUE;
          bcd_n       = '0;
          cnt_n       = '0;
          state_n     = S_CONVERT;
        end
      end

      S_CONVERT: begin
        {bcd_n, shift_reg_n} = {add3(bcd), shift_reg} << 1;
        cnt_n = cnt + 4'd1;
        if (cnt == 4'd9) begin
          state_n = S_LOAD;
        end
      end

      S_LOAD: begin
        hex0_n        = seg_code(bcd[3:0]);
        hex1_n        = blank1 ? SEG_BLANK : seg_code(bcd[7:4]);
        hex2_n        = blank2 ? SEG_BLANK : seg_code(bcd[11:8]);
        hex3_n        = blank3 ? SEG_BLANK : seg_code(bcd[15:12]);
        last_n        = captured;
        shown_valid_n = 1'b1;
        state_n       = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign HEX0 = hex0_q;
  assign HEX1 = hex1_q;
  assign HEX2 = hex2_q;
  assign HEX3 = hex3_q;
  assign BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_bcd_seven_seg_driver.sv
module tb_bcd_seven_seg_driver;

  logic       clk;
  logic       rst_n;
  logic [9:0] value_a, value_b;
  logic [7:0] a_hex0, a_hex1, a_hex2, a_hex3;
  logic [7:0] b_hex0, b_hex1, b_hex2, b_hex3;
  logic       a_busy, b_busy;

  int n_total = 0;
  int n_bad   = 0;

  bcd_seven_seg_driver #(.BLANK_LEADING(1'b1)) dut_a (
    .CLK(clk), .RST_N(rst_n), .VALUE(value_a),
    .HEX0(a_hex0), .HEX1(a_hex1), .HEX2(a_hex2), .HEX3(a_hex3), .BUSY(a_busy)
  );

  bcd_seven_seg_driver #(.BLANK_LEADING(1'b0)) dut_b (
    .CLK(clk), .RST_N(rst_n), .VALUE(value_b),
    .HEX0(b_hex0), .HEX1(b_hex1), .HEX2(b_hex2), .HEX3(b_hex3), .BUSY(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Reference segment code for one decimal digit.
  function automatic logic [7:0] seg_ref(input int d);
    logic [7:0] tbl [0:9];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return tbl[d];
  endfunction

  // Expected digit at position pos (0=ones..3=thousands) for value v.
  function automatic logic [7:0] exp_hex(input int v, input bit blank, input int pos);
    int p10;
    p10 = 1;
    for (int i = 0; i < pos; i++) p10 = p10 * 10;
    if (blank && pos > 0 && v < p10) return 8'hFF;
    return seg_ref((v / p10) % 10);
  endfunction

  task automatic chk_a(input string tag, input int v);
    chk({tag, ".hex0"}, 16'(a_hex0), 16'(exp_hex(v, 1'b1, 0)));
    chk({tag, ".hex1"}, 16'(a_hex1), 16'(exp_hex(v, 1'b1, 1)));
    chk({tag, ".hex2"}, 16'(a_hex2), 16'(exp_hex(v, 1'b1, 2)));
    chk({tag, ".hex3"}, 16'(a_hex3), 16'(exp_hex(v, 1'b1, 3)));
  endtask

  task automatic chk_b(input string tag, input int v);
    chk({tag, ".b_hex0"}, 16'(b_hex0), 16'(exp_hex(v, 1'b0, 0)));
    chk({tag, ".b_hex1"}, 16'(b_hex1), 16'(exp_hex(v, 1'b0, 1)));
    chk({tag, ".b_hex2"}, 16'(b_hex2), 16'(exp_hex(v, 1'b0, 2)));
    chk({tag, ".b_hex3"}, 16'(b_hex3), 16'(exp_hex(v, 1'b0, 3)));
  endtask

  // Next edge is the capture edge E0; walk E0..E11 checking BUSY and that HEX
  // holds its old value until E11, then check the new display.
  task automatic conv_a(input string tag, input int v);
    logic [7:0] old0;
    old0 = a_hex0;
    for (int e = 0; e <= 10; e++) begin
      edge1();
      chk({tag, ".busy_run"}, 16'(a_busy), 16'(1));
      chk({tag, ".hold"}, 16'(a_hex0), 16'(old0));
    end
    edge1();
    chk({tag, ".busy_done"}, 16'(a_busy), 16'(0));
    chk_a(tag, v);
  endtask

  initial begin
    rst_n   = 1'b0;
    value_a = 10'd0;
    value_b = 10'd5;
    #12;
    chk("rst.hex0", 16'(a_hex0), 16'hFF);
    chk("rst.hex1", 16'(a_hex1), 16'hFF);
    chk("rst.hex2", 16'(a_hex2), 16'hFF);
    chk("rst.hex3", 16'(a_hex3), 16'hFF);
    chk("rst.busy", 16'(a_busy), 16'(0));
    chk("rst.b_busy", 16'(b_busy), 16'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First edge after release converts the current VALUE (0).
    conv_a("zero", 0);
    chk_b("noblank5", 5);   // BLANK_LEADING=0: C0 C0 C0 92

    // Maximum value, then no further activity while it is held.
    value_a = 10'd1023;
    conv_a("max", 1023);
    for (int i = 0; i < 20; i++) begin
      edge1();
      chk("max.idle_busy", 16'(a_busy), 16'(0));
    end

    value_a = 10'd999;
    conv_a("v999", 999);
    value_a = 10'd10;
    conv_a("v10", 10);

    // Mid-conversion change is ignored until back in IDLE.
    value_a = 10'd100;
    edge1();                       // E0
    chk("mid.busy_e0", 16'(a_busy), 16'(1));
    edge1(); edge1();              // E1, E2
    value_a = 10'd42;
    for (int e = 3; e <= 11; e++) edge1();
    chk("mid.busy_e11", 16'(a_busy), 16'(0));
    chk_a("mid100", 100);
    edge1();                       // E12 recaptures 42
    chk("mid.busy_e12", 16'(a_busy), 16'(1));
    for (int e = 13; e <= 23; e++) edge1();
    chk("mid.busy_e23", 16'(a_busy), 16'(0));
    chk_a("mid42", 42);

    // Reset in the middle of a conversion.
    value_a = 10'd512;
    for (int e = 0; e <= 4; e++) edge1();
    rst_n = 1'b0;
    #1;
    chk("rstmid.hex0", 16'(a_hex0), 16'hFF);
    chk("rstmid.hex1", 16'(a_hex1), 16'hFF);
    chk("rstmid.hex2", 16'(a_hex2), 16'hFF);
    chk("rstmid.hex3", 16'(a_hex3), 16'hFF);
    chk("rstmid.busy", 16'(a_busy), 16'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    conv_a("v512", 512);

    // Sweep every value through both instances.
    for (int v = 0; v < 1024; v++) begin
      value_a = 10'(v);
      value_b = 10'(v);
      for (int e = 0; e < 12; e++) edge1();
      chk_a("sweep", v);
      chk_b("sweep", v);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Watchdog in case the bench itself stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcd_seven_seg_driver.md
# bcd_seven_seg_driver

Sequential display stage that sits directly downstream of the 4-to-1 mode multiplexer. It takes the selected 10-bit unsigned result and converts it to four BCD digits using an iterative shift-and-add-3 (double-dabble) engine. It then drives four active-low 7-segment digits with optional leading-zero blanking. A new conversion starts automatically whenever the selected value differs from the last value displayed.

## Interface
- BLANK_LEADING, default 1: 1 blanks leading zero digits; HEX0 is never blanked. 0 shows all four digits.
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  reset, asynchronous and active-low.
- VALUE  input  10  unsigned value from the mode multiplexer output, range 0..1023.
- HEX0  output  8  ones digit, active-low {DP,g,f,e,d,c,b,a}.
- HEX1  output  8  tens digit, same format.
- HEX2  output  8  hundreds digit, same format.
- HEX3  output  8  thousands digit, same format.
- BUSY  output  1  high while a conversion is in progress (CONVERT or LOAD).

## Operation
- States:
  - IDLE: compare VALUE with LAST, the 10-bit value last displayed.
    - If VALUE != LAST, or SHOWN_VALID=0: capture VALUE into the shift register, clear the 16-bit BCD accumulator, set CNT=0, go to CONVERT.
    - Otherwise stay in IDLE.
  - CONVERT: each edge performs one step.
    - For each of the 4 BCD nibbles, add 3 if the nibble is >= 5.
    - Then shift {BCD, SHIFT} left by 1 and increment CNT.
    - After the step with CNT=9 (10 steps total), go to LOAD.
  - LOAD: register the encoded digits into HEX0..HEX3, set LAST to the captured value and SHOWN_VALID=1, go to IDLE.
- VALUE is sampled only in IDLE. Changes during CONVERT or LOAD are ignored until the machine is back in IDLE, where the compare picks them up.
- Segment codes (hex, DP bit7 always 1): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF.
- Blanking (BLANK_LEADING=1):
  - HEX3 is blank if the thousands digit is 0.
  - HEX2 is blank if thousands and hundreds are both 0.
  - HEX1 is blank if thousands, hundreds and tens are all 0.
  - HEX0 is always shown.
- Width rules:
  - The thousands nibble only ever reaches 0 or 1, since 1023 is the maximum.
  - BCD nibbles never exceed 9 after a completed conversion.
  - Any out-of-range nibble code (10..15, unreachable) encodes as blank FF.
- Reset (asserted at any time, including mid-conversion):
  - HEX0..HEX3 = FF, BUSY=0, state IDLE, SHOWN_VALID=0, LAST=0, CNT=0, accumulators cleared.
  - The first edge after release always starts a conversion of the current VALUE.

## Timing
- Capture edge E0 (IDLE, change detected). Conversion steps on E1..E10. HEX registers update on E11.
- Latency is 12 rising edges from the capture edge, inclusive.
- BUSY rises after E0, is high through E11, and is low after E11.
- Minimum spacing between successive display updates is 12 cycles. A back-to-back change recaptures on E12.
- All outputs are registered; there are no combinational paths from VALUE to HEX or BUSY.
- HEX outputs hold their previous value throughout a conversion. There is no intermediate glitch.

## Test plan
- Reset: assert RST_N=0 with VALUE=0 → HEX3..HEX0=FF, BUSY=0. Release → E0..E11, BUSY high E1..E11. Then HEX0=C0, HEX1..HEX3=FF.
- Max value: VALUE=1023 → after 12 edges HEX3=F9, HEX2=C0, HEX1=A4, HEX0=B0, BUSY=0. Holding VALUE produces no further BUSY pulse.
- Blanking boundary: VALUE=999 → HEX3=FF, HEX2=HEX1=HEX0=90. VALUE=10 → HEX3=HEX2=FF, HEX1=F9, HEX0=C0.
- BLANK_LEADING=0: VALUE=5 → HEX3=HEX2=HEX1=C0, HEX0=92.
- Mid-conversion change: VALUE=100 captured at E0, VALUE=42 applied at E3.
  - E11 shows 100: HEX2=F9, HEX1=C0, HEX0=C0.
  - E12 recaptures 42; E23 shows HEX1=99, HEX0=A4, HEX2=HEX3=FF.
- Reset mid-conversion: RST_N low at E5 of a VALUE=512 conversion → outputs immediately FF, BUSY=0. After release, 512 displays 12 edges later. Follow with an exhaustive sweep 0..1023 against a reference model.
